seq_bit_serializer: RTL and testbench

Parallel-in/serial-out front end for the fsm_seq_dec 10010 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Emits them one bit per consumed cycle on dout, paced by bit_en.
- The detector's data input is driven from dout; dout_valid/bit_en mark the cycles on which a bit is meaningful.

---
 rtl/fsm_pkg.sv | 18 +
 rtl/seq_bit_serializer_if.sv | 25 ++
 rtl/seq_bit_serializer.sv | 85 ++++++++
 tb/tb_seq_bit_serializer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the bit serializer and the 10010 sequence detector.
package fsm_pkg;

    // Serializer control states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Pattern recognised by the downstream fsm_seq_dec detector
    localparam logic [4:0] SEQ_10010 = 5'b10010;

    // Even parity of a 5-bit pattern, handy for pattern sanity checks
    function automatic logic parity5(input logic [4:0] v);
        parity5 = ^v;
    endfunction

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Parallel-in handshake and serial-out bus of the bit serializer.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             bit_en;
    logic             dout;
    logic             dout_valid;
    logic             last;
    logic             busy;

    // Upstream producer / downstream consumer side
    modport master (
        output din, din_valid, bit_en,
        input  din_ready, dout, dout_valid, last, busy
    );

    // Serializer side
    modport slave (
        input  din, din_valid, bit_en,
        output din_ready, dout, dout_valid, last, busy
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-in / serial-out front end: takes WIDTH-bit words over valid/ready
// and emits one bit per consumed cycle, back-to-back words without a bubble.
module seq_bit_serializer
    import fsm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                clk,
    input logic                rst,
    seq_bit_serializer_if.slave bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0] cnt_r;

    logic shift_s;
    logic last_s;
    logic consume_s;
    logic ready_s;
    logic accept_s;
    logic out_bit_s;

    assign shift_s   = (state_r == ST_SHIFT);
    assign last_s    = shift_s && (cnt_r == CNT_LAST);
    assign consume_s = shift_s && bus.bit_en;
    // A new word may enter while idle, or on the very edge the final bit leaves
    assign ready_s   = !shift_s || (consume_s && last_s);
    assign accept_s  = bus.din_valid && ready_s;
    // Output end of the shift register; zero-fill trails behind it
    assign out_bit_s = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];

    assign bus.din_ready  = ready_s;
    assign bus.dout       = out_bit_s;
    assign bus.dout_valid = shift_s;
    assign bus.busy       = shift_s;
    assign bus.last       = last_s;

    // Control FSM with shift register and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shreg_r <= bus.din;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (consume_s && last_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (accept_s) begin
                            shreg_r <= bus.din;
                            state_r <= ST_SHIFT;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else if (consume_s) begin
                        shreg_r <= MSB_FIRST ? {shreg_r[WIDTH-2:0], 1'b0}
                                             : {1'b0, shreg_r[WIDTH-1:1]};
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: an MSB-first and an LSB-first
// instance checked cycle by cycle against a queue-of-bits reference model.
module tb_seq_bit_serializer;
    import fsm_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   fails;

    // Reference model: bits still to be emitted, each {bit, is_last}
    logic [1:0] mq[$];

    seq_bit_serializer_if #(.WIDTH(8)) ifa ();
    seq_bit_serializer_if #(.WIDTH(8)) ifb ();

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(ifa));
    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive, observe {ready,valid,dout,last,busy}, advance model.
    // ev = {accepted, consumed, consumed_bit}
    task automatic step(input bit sel, input logic dv, input logic [7:0] d, input logic be,
                        output logic [4:0] obs, output logic [4:0] exp,
                        output logic [4:0] msk, output logic [2:0] ev);
        logic ne, cons, rdy, acc;
        logic [1:0] fb;
        ifa.din_valid = sel ? 1'b0 : dv;  ifa.din = sel ? 8'h00 : d;  ifa.bit_en = sel ? 1'b0 : be;
        ifb.din_valid = sel ? dv : 1'b0;  ifb.din = sel ? d : 8'h00;  ifb.bit_en = sel ? be : 1'b0;
        #1;
        obs = sel ? {ifb.din_ready, ifb.dout_valid, ifb.dout, ifb.last, ifb.busy}
                  : {ifa.din_ready, ifa.dout_valid, ifa.dout, ifa.last, ifa.busy};
        ne   = (mq.size() != 0);
        fb   = ne ? mq[0] : 2'b00;
        cons = ne && be;
        rdy  = !ne || (cons && fb[0]);
        acc  = dv && rdy;
        exp  = {rdy, ne, fb[1], fb[0], ne};
        msk  = ne ? 5'b11111 : 5'b11011;
        ev   = {acc, cons, fb[1]};
        @(posedge clk);
        if (cons) void'(mq.pop_front());
        if (acc) begin
            for (int i = 0; i < 8; i++) mq.push_back({(sel ? d[i] : d[7-i]), (i == 7)});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.din_valid = 1'b0; ifa.din = 8'h00; ifa.bit_en = 1'b0;
        ifb.din_valid = 1'b0; ifb.din = 8'h00; ifb.bit_en = 1'b0;
        mq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({ifa.dout_valid, ifa.dout, ifa.last, ifa.busy, ifb.dout_valid, ifb.dout, ifb.last, ifb.busy} !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs got %b want 00000000",
                     {ifa.dout_valid, ifa.dout, ifa.last, ifa.busy, ifb.dout_valid, ifb.dout, ifb.last, ifb.busy});
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({ifa.din_ready, ifb.din_ready} !== 2'b11) begin
            fails++;
            $display("FAIL reset_ready got %b want 11", {ifa.din_ready, ifb.din_ready});
        end
        @(negedge clk);
    endtask

    // Single word 0x92, bit_en held high
    task automatic test_single();
        logic [4:0] obs, exp, msk; logic [2:0] ev;
        logic [7:0] strm; int ncons;
        strm = 8'h00; ncons = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, (k == 0), 8'h92, 1'b1, obs, exp, msk, ev);
            tests_run++;
            if ((obs & msk) !== (exp & msk)) begin
                fails++; $display("FAIL single cyc %0d got %b want %b", k, obs & msk, exp & msk);
            end
            if (ev[1]) begin strm = {strm[6:0], ev[0]}; ncons++; end
        end
        tests_run++;
        if (strm !== 8'h92 || ncons != 8) begin
            fails++; $display("FAIL single_stream got %h/%0d want 92/8", strm, ncons);
        end
        tests_run++;
        if (strm[7:3] !== SEQ_10010) begin
            fails++; $display("FAIL single_seq got %b want %b", strm[7:3], SEQ_10010);
        end
    endtask

    // 0xA5 then 0x3C with din_valid held: no bubble between words
    task automatic test_back_to_back();
        logic [4:0] obs, exp, msk; logic [2:0] ev;
        logic [15:0] strm; int run, maxrun, nacc;
        strm = 16'h0; run = 0; maxrun = 0; nacc = 0;
        for (int k = 0; k < 22; k++) begin
            step(1'b0, (nacc < 2), (nacc == 0) ? 8'hA5 : 8'h3C, 1'b1, obs, exp, msk, ev);
            tests_run++;
            if ((obs & msk) !== (exp & msk)) begin
                fails++; $display("FAIL b2b cyc %0d got %b want %b", k, obs & msk, exp & msk);
            end
            if (ev[2]) nacc++;
            if (ev[1]) strm = {strm[14:0], ev[0]};
            run = obs[3] ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        tests_run++;
        if (strm !== 16'hA53C || maxrun != 16) begin
            fails++; $display("FAIL b2b_stream got %h run %0d want a53c run 16", strm, maxrun);
        end
    endtask

    // bit_en every third cycle: each bit held until consumed
    task automatic test_pacing();
        logic [4:0] obs, exp, msk; logic [2:0] ev;
        logic [7:0] strm; int lastk;
        strm = 8'h00; lastk = -1;
        step(1'b0, 1'b1, 8'h92, 1'b0, obs, exp, msk, ev);
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 1'b0, 8'h00, (k % 3 == 2), obs, exp, msk, ev);
            tests_run++;
            if ((obs & msk) !== (exp & msk)) begin
                fails++; $display("FAIL pacing cyc %0d got %b want %b", k, obs & msk, exp & msk);
            end
            if (ev[1]) begin strm = {strm[6:0], ev[0]}; lastk = k; end
        end
        tests_run++;
        if (strm !== 8'h92 || lastk != 23) begin
            fails++; $display("FAIL pacing_stream got %h end %0d want 92 end 23", strm, lastk);
        end
    endtask

    // New word offered mid-word: only taken on the last-bit consume
    task automatic test_backpressure();
        logic [4:0] obs, exp, msk; logic [2:0] ev;
        logic [15:0] strm; int acck; bit taken;
        strm = 16'h0; acck = -1; taken = 1'b0;
        step(1'b0, 1'b1, 8'h92, 1'b1, obs, exp, msk, ev);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, (k >= 3) && !taken, 8'h5A, 1'b1, obs, exp, msk, ev);
            tests_run++;
            if ((obs & msk) !== (exp & msk)) begin
                fails++; $display("FAIL backpressure cyc %0d got %b want %b", k, obs & msk, exp & msk);
            end
            if (ev[2]) begin taken = 1'b1; acck = k; end
            if (ev[1]) strm = {strm[14:0], ev[0]};
        end
        tests_run++;
        if (strm !== 16'h925A || acck != 7) begin
            fails++; $display("FAIL backpressure_stream got %h acc %0d want 925a acc 7", strm, acck);
        end
    endtask

    // Async reset after 3 bits of 0xFF, then a clean 0x01
    task automatic test_reset_mid();
        logic [4:0] obs, exp, msk; logic [2:0] ev;
        logic [7:0] strm;
        strm = 8'h00;
        for (int k = 0; k < 4; k++) step(1'b0, (k == 0), 8'hFF, 1'b1, obs, exp, msk, ev);
        ifa.din_valid = 1'b0; ifa.bit_en = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({ifa.dout_valid, ifa.dout, ifa.busy, ifa.last} !== 4'b0000) begin
            fails++; $display("FAIL reset_mid got %b want 0000", {ifa.dout_valid, ifa.dout, ifa.busy, ifa.last});
        end
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 11; k++) begin
            step(1'b0, (k == 0), 8'h01, 1'b1, obs, exp, msk, ev);
            tests_run++;
            if ((obs & msk) !== (exp & msk)) begin
                fails++; $display("FAIL reset_mid cyc %0d got %b want %b", k, obs & msk, exp & msk);
            end
            if (ev[1]) strm = {strm[6:0], ev[0]};
        end
        tests_run++;
        if (strm !== 8'h01) begin
            fails++; $display("FAIL reset_mid_stream got %h want 01", strm);
        end
    endtask

    // LSB-first instance: 0x09 goes out as 1,0,0,1,0,0,0,0
    task automatic test_lsb_first();
        logic [4:0] obs, exp, msk; logic [2:0] ev;
        logic [7:0] strm;
        strm = 8'h00;
        for (int k = 0; k < 11; k++) begin
            step(1'b1, (k == 0), 8'h09, 1'b1, obs, exp, msk, ev);
            tests_run++;
            if ((obs & msk) !== (exp & msk)) begin
                fails++; $display("FAIL lsb cyc %0d got %b want %b", k, obs & msk, exp & msk);
            end
            if (ev[1]) strm = {strm[6:0], ev[0]};
        end
        tests_run++;
        if (strm !== 8'h90) begin
            fails++; $display("FAIL lsb_stream got %b want 10010000", strm);
        end
    endtask

    // Random valid/data/bit_en on both instances, then drain
    task automatic test_random();
        logic [4:0] obs, exp, msk; logic [2:0] ev;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 320; k++) begin
                step(s[0], (k < 300) && ($urandom_range(3) != 0), 8'($urandom),
                     ($urandom_range(2) != 0) || (k >= 300), obs, exp, msk, ev);
                tests_run++;
                if ((obs & msk) !== (exp & msk)) begin
                    fails++; $display("FAIL random%0d cyc %0d got %b want %b", s, k, obs & msk, exp & msk);
                end
            end
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_pacing();
        test_backpressure();
        test_reset_mid();
        test_lsb_first();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
